kd_leaf_endpoint: RTL and testbench
===================================

# kd_leaf_endpoint

Terminal (leaf) endpoint of the kd-tree parent/child command-data link. It is the child end of the link: it accepts commands and 24-bit RGB data from a parent `node` on the top port and returns responses on the same link. It replaces the constant `dne` and `0` ties on the child ports of the bottom tree level. It holds exactly one center and answers reset, fill, axis-configure, swap and sort commands with registered responses.

## Interface
- `CMD_W`, default 5: command field width.
- `DATA_W`, default 24: data width; the value is packed {R[23:16], G[15:8], B[7:0]}.
- `clk`  in  1  clock; everything is rising-edge.
- `reset`  in  1  reset, synchronous, active-high.
- `command_from_top`  in  CMD_W  command from the parent.
- `data_from_top`  in  DATA_W  data from the parent.
- `command_to_top`  out  CMD_W  registered response to the parent.
- `data_to_top`  out  DATA_W  registered response data.
- `proto_err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Command codes:
  - nop 00, center_fill 01, configure_sort_axis 02, recieve_center 03, switch_with_left 04, center_fill_done 05, configure_sort_axis_done 07.
  - busy 08, start_sorting 09, ready_to_sort 0a, dne 10, rst_done 1e, rst 1f.
- Internal state: `center` [23:0], `valid`, `axis` [1:0], `prev_cmd` [4:0], `initd`.
- Edge rule:
  - An action executes only on a new command, i.e. `command_from_top != prev_cmd`.
  - `prev_cmd` is registered every cycle.
  - A held command repeats its last response and never repeats the action.
- States: UNINIT, EMPTY, FULL.
  - Reset enters UNINIT.
  - rst enters EMPTY from any state.
  - center_fill or switch_with_left enters FULL from EMPTY.
- Actions and responses, one per new command:
  - rst: clear center, valid and axis; set initd. Response rst_done, data 0.
  - center_fill in EMPTY: center <= data_from_top, valid <= 1. Response center_fill_done, data = the captured value.
  - center_fill in FULL: data is ignored. Response center_fill_done, data = current center.
  - configure_sort_axis: axis <= data_from_top[1:0]. The value 3 is stored as 0. Response configure_sort_axis_done, data 0.
  - switch_with_left: unconditional swap. center <= data_from_top, data_to_top <= old center, valid <= 1. Response recieve_center.
  - start_sorting when valid: response ready_to_sort, data = center.
  - start_sorting when not valid: response dne, data 0.
  - nop: response nop, data 0.
  - Any other code: response nop, data 0, no state change.
- Sort key used by the parent: R for axis 0, G for axis 1, B for axis 2. The leaf only stores `axis`; it performs no compare.

## Timing
- Response latency: 1 cycle. A command sampled at edge N appears on `command_to_top`/`data_to_top` after edge N.
- Held command: the response is held unchanged for as long as the command is held.
- Reset values: command_to_top = nop, data_to_top = 0, proto_err = 0, center = 0, valid = 0, axis = 0, prev_cmd = nop, initd = 0.
- Reset has priority over any command in the same cycle.
- Reset mid-swap or mid-fill discards the action. The leaf returns to UNINIT and responds nop next cycle.
- rst while FULL clears the center. rst_done follows one cycle later.
- Back-to-back distinct commands act on consecutive cycles. Example: switch_with_left then start_sorting returns the swapped-in value on the second response.
- Re-issuing the same command requires an intervening different command; nop is sufficient.

## Configuration
- `KD_LEAF_PROTOCOL_CHECK_EN` defined:
  - `proto_err` is set on a new command that is either an undefined code, or any code other than rst or nop while `initd` = 0.
  - It is cleared only by `reset`.
  - The offending command still gets its normal response.
- Not defined: `proto_err` is tied 0 and no check logic is built.

## Test plan
- Reset held 2 cycles, then rst held 3 cycles -> command_to_top: nop, then rst_done for 3 cycles, data 0; nop after rst is released to nop.
- rst, nop, then center_fill with data 0xA1B2C3 and then 0x112233 on the next cycle (command held) -> center_fill_done with data 0xA1B2C3 both cycles; a later start_sorting returns ready_to_sort with 0xA1B2C3.
- After rst: start_sorting -> dne with data 0. Then nop, then switch_with_left with data 0x0000FF -> recieve_center with data 0. Then nop, start_sorting -> ready_to_sort with 0x0000FF.
- FULL with 0x102030: configure_sort_axis with data 3 -> configure_sort_axis_done, axis = 0. switch_with_left with 0x405060 -> recieve_center with 0x102030; center = 0x405060.
- Reset asserted on the same cycle as switch_with_left -> no swap; next response nop; center = 0.
- With the macro: switch_with_left before any rst -> proto_err = 1 and stays 1 through a later rst. Without the macro -> proto_err stays 0.

Source files
------------

// File: rtl/kd_leaf_if.sv
// Parent/child command-data link of the kd-tree.
// The parent drives the master modport; the child end uses the slave modport.
interface kd_leaf_if #(
  parameter int CMD_W  = 5,
  parameter int DATA_W = 24
);
  logic [CMD_W-1:0]  command_from_top;
  logic [DATA_W-1:0] data_from_top;
  logic [CMD_W-1:0]  command_to_top;
  logic [DATA_W-1:0] data_to_top;

  modport master (
    output command_from_top,
    output data_from_top,
    input  command_to_top,
    input  data_to_top
  );

  modport slave (
    input  command_from_top,
    input  data_from_top,
    output command_to_top,
    output data_to_top
  );
endinterface

// File: rtl/kd_leaf_endpoint.sv
// Leaf endpoint of the kd-tree link: holds one center, answers parent commands.
// Optional protocol checker enabled by defining KD_LEAF_PROTOCOL_CHECK_EN.
module kd_leaf_endpoint #(
  parameter int CMD_W  = 5,
  parameter int DATA_W = 24
) (
  input  logic     clk,
  input  logic     reset,
  kd_leaf_if.slave link,
  output logic     proto_err
);

  localparam logic [CMD_W-1:0] NOP        = CMD_W'(5'h00);
  localparam logic [CMD_W-1:0] FILL       = CMD_W'(5'h01);
  localparam logic [CMD_W-1:0] CFG_AXIS   = CMD_W'(5'h02);
  localparam logic [CMD_W-1:0] RECV_CTR   = CMD_W'(5'h03);
  localparam logic [CMD_W-1:0] SWAP_LEFT  = CMD_W'(5'h04);
  localparam logic [CMD_W-1:0] FILL_DONE  = CMD_W'(5'h05);
  localparam logic [CMD_W-1:0] CFG_DONE   = CMD_W'(5'h07);
  localparam logic [CMD_W-1:0] BUSY       = CMD_W'(5'h08);
  localparam logic [CMD_W-1:0] START_SORT = CMD_W'(5'h09);
  localparam logic [CMD_W-1:0] RDY_SORT   = CMD_W'(5'h0a);
  localparam logic [CMD_W-1:0] DNE        = CMD_W'(5'h10);
  localparam logic [CMD_W-1:0] RST_DONE   = CMD_W'(5'h1e);
  localparam logic [CMD_W-1:0] RST        = CMD_W'(5'h1f);

  typedef enum logic [1:0] {
    UNINIT,
    EMPTY,
    FULL
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] center;
  logic              valid;
  logic [1:0]        axis;
  logic [CMD_W-1:0]  prev_cmd;
  logic              initd;

  logic [CMD_W-1:0]  resp_cmd;
  logic [DATA_W-1:0] resp_data;

  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] din;
  logic              is_new;

  assign cmd    = link.command_from_top;
  assign din    = link.data_from_top;
  assign is_new = (cmd != prev_cmd);

  assign link.command_to_top = resp_cmd;
  assign link.data_to_top    = resp_data;

  // Edge-triggered command FSM; a held command keeps its last response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNINIT;
      center    <= '0;
      valid     <= 1'b0;
      axis      <= 2'd0;
      prev_cmd  <= NOP;
      initd     <= 1'b0;
      resp_cmd  <= NOP;
      resp_data <= '0;
    end else begin
      prev_cmd <= cmd;
      if (is_new) begin
        unique case (cmd)
          RST: begin
            state     <= EMPTY;
            center    <= '0;
            valid     <= 1'b0;
            axis      <= 2'd0;
            initd     <= 1'b1;
            resp_cmd  <= RST_DONE;
            resp_data <= '0;
          end
          FILL: begin
            resp_cmd <= FILL_DONE;
            if (!valid) begin
              center    <= din;
              valid     <= 1'b1;
              resp_data <= din;
              if (state == EMPTY) state <= FULL;
            end else begin
              resp_data <= center;
            end
          end
          CFG_AXIS: begin
            axis      <= (din[1:0] == 2'd3) ? 2'd0 : din[1:0];
            resp_cmd  <= CFG_DONE;
            resp_data <= '0;
          end
          SWAP_LEFT: begin
            center    <= din;
            valid     <= 1'b1;
            resp_cmd  <= RECV_CTR;
            resp_data <= center;
            if (state == EMPTY) state <= FULL;
          end
          START_SORT: begin
            if (valid) begin
              resp_cmd  <= RDY_SORT;
              resp_data <= center;
            end else begin
              resp_cmd  <= DNE;
              resp_data <= '0;
            end
          end
          default: begin
            resp_cmd  <= NOP;
            resp_data <= '0;
          end
        endcase
      end
    end
  end

  // Structural invariants: axis never holds 3, UNINIT tracks initd.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (axis != 2'd3);
      assert ((state == UNINIT) == !initd);
    end
  end

`ifdef KD_LEAF_PROTOCOL_CHECK_EN
  logic defined_code;
  logic bad_cmd;
  logic err_q;

  // Classify the incoming code against the link command set.
  always_comb begin
    defined_code = 1'b0;
    unique case (cmd)
      NOP, FILL, CFG_AXIS, RECV_CTR, SWAP_LEFT,
      FILL_DONE, CFG_DONE, BUSY, START_SORT,
      RDY_SORT, DNE, RST_DONE, RST: defined_code = 1'b1;
      default: defined_code = 1'b0;
    endcase
  end

  assign bad_cmd = !defined_code ||
                   (!initd && cmd != RST && cmd != NOP);

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (is_new && bad_cmd) err_q <= 1'b1;
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_kd_leaf_endpoint.sv
// Directed bench for kd_leaf_endpoint.
// Expected responses are hand-computed per scenario.
module tb_kd_leaf_endpoint;

  localparam logic [4:0] NOP   = 5'h00;
  localparam logic [4:0] FILL  = 5'h01;
  localparam logic [4:0] CFG   = 5'h02;
  localparam logic [4:0] RECV  = 5'h03;
  localparam logic [4:0] SWAP  = 5'h04;
  localparam logic [4:0] FDONE = 5'h05;
  localparam logic [4:0] CDONE = 5'h07;
  localparam logic [4:0] BUSY  = 5'h08;
  localparam logic [4:0] START = 5'h09;
  localparam logic [4:0] RDY   = 5'h0a;
  localparam logic [4:0] DNE   = 5'h10;
  localparam logic [4:0] RDONE = 5'h1e;
  localparam logic [4:0] RST   = 5'h1f;

`ifdef KD_LEAF_PROTOCOL_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic proto_err;
  int   n_chk = 0;
  int   n_fail = 0;

  kd_leaf_if #(.CMD_W(5), .DATA_W(24)) link ();

  kd_leaf_endpoint #(.CMD_W(5), .DATA_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .link      (link),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic r, input logic [4:0] c,
                       input logic [23:0] d);
    @(negedge clk);
    reset = r;
    link.command_from_top = c;
    link.data_from_top = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1'b1, NOP, 24'h0);
    cycle(1'b1, NOP, 24'h0);
    n_chk++;
    if (link.command_to_top !== NOP || link.data_to_top !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h/%h want %h/0",
               link.command_to_top, link.data_to_top, NOP);
    end
    n_chk++;
    if (proto_err !== 1'b0 || dut.center !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: perr=%b center=%h want 0/0",
               proto_err, dut.center);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, RST, 24'h0);
      n_chk++;
      if (link.command_to_top !== RDONE || link.data_to_top !== 24'h0) begin
        n_fail++;
        $display("FAIL rst_held[%0d]: got %h/%h want %h/0",
                 i, link.command_to_top, link.data_to_top, RDONE);
      end
    end
    cycle(1'b0, NOP, 24'h0);
    n_chk++;
    if (link.command_to_top !== NOP || link.data_to_top !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_release: got %h/%h want %h/0",
               link.command_to_top, link.data_to_top, NOP);
    end
  endtask

  task automatic test_fill;
    cycle(1'b0, RST, 24'h0);
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, FILL, 24'hA1B2C3);
    n_chk++;
    if (link.command_to_top !== FDONE || link.data_to_top !== 24'hA1B2C3) begin
      n_fail++;
      $display("FAIL fill_first: got %h/%h want %h/a1b2c3",
               link.command_to_top, link.data_to_top, FDONE);
    end
    cycle(1'b0, FILL, 24'h112233);
    n_chk++;
    if (link.command_to_top !== FDONE || link.data_to_top !== 24'hA1B2C3) begin
      n_fail++;
      $display("FAIL fill_held: got %h/%h want %h/a1b2c3",
               link.command_to_top, link.data_to_top, FDONE);
    end
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, START, 24'h0);
    n_chk++;
    if (link.command_to_top !== RDY || link.data_to_top !== 24'hA1B2C3) begin
      n_fail++;
      $display("FAIL fill_sort: got %h/%h want %h/a1b2c3",
               link.command_to_top, link.data_to_top, RDY);
    end
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, FILL, 24'h445566);
    n_chk++;
    if (link.command_to_top !== FDONE || link.data_to_top !== 24'hA1B2C3) begin
      n_fail++;
      $display("FAIL fill_full: got %h/%h want %h/a1b2c3",
               link.command_to_top, link.data_to_top, FDONE);
    end
  endtask

  task automatic test_swap_empty;
    cycle(1'b0, RST, 24'h0);
    cycle(1'b0, START, 24'h0);
    n_chk++;
    if (link.command_to_top !== DNE || link.data_to_top !== 24'h0) begin
      n_fail++;
      $display("FAIL empty_sort: got %h/%h want %h/0",
               link.command_to_top, link.data_to_top, DNE);
    end
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, SWAP, 24'h0000FF);
    n_chk++;
    if (link.command_to_top !== RECV || link.data_to_top !== 24'h0) begin
      n_fail++;
      $display("FAIL empty_swap: got %h/%h want %h/0",
               link.command_to_top, link.data_to_top, RECV);
    end
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, START, 24'h0);
    n_chk++;
    if (link.command_to_top !== RDY || link.data_to_top !== 24'h0000FF) begin
      n_fail++;
      $display("FAIL swap_sort: got %h/%h want %h/0000ff",
               link.command_to_top, link.data_to_top, RDY);
    end
  endtask

  task automatic test_axis_swap;
    cycle(1'b0, RST, 24'h0);
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, FILL, 24'h102030);
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, CFG, 24'h000002);
    n_chk++;
    if (link.command_to_top !== CDONE || link.data_to_top !== 24'h0 ||
        dut.axis !== 2'd2) begin
      n_fail++;
      $display("FAIL axis_2: got %h/%h axis=%0d want %h/0 axis=2",
               link.command_to_top, link.data_to_top, dut.axis, CDONE);
    end
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, CFG, 24'h000003);
    n_chk++;
    if (link.command_to_top !== CDONE || dut.axis !== 2'd0) begin
      n_fail++;
      $display("FAIL axis_3: got %h axis=%0d want %h axis=0",
               link.command_to_top, dut.axis, CDONE);
    end
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, SWAP, 24'h405060);
    n_chk++;
    if (link.command_to_top !== RECV || link.data_to_top !== 24'h102030 ||
        dut.center !== 24'h405060) begin
      n_fail++;
      $display("FAIL full_swap: got %h/%h ctr=%h want %h/102030 ctr=405060",
               link.command_to_top, link.data_to_top, dut.center, RECV);
    end
    cycle(1'b0, SWAP, 24'h777777);
    n_chk++;
    if (link.command_to_top !== RECV || link.data_to_top !== 24'h102030 ||
        dut.center !== 24'h405060) begin
      n_fail++;
      $display("FAIL swap_held: got %h/%h ctr=%h want %h/102030 ctr=405060",
               link.command_to_top, link.data_to_top, dut.center, RECV);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, RST, 24'h0);
    cycle(1'b0, SWAP, 24'h0A0B0C);
    cycle(1'b0, START, 24'h0);
    n_chk++;
    if (link.command_to_top !== RDY || link.data_to_top !== 24'h0A0B0C) begin
      n_fail++;
      $display("FAIL b2b_sort: got %h/%h want %h/0a0b0c",
               link.command_to_top, link.data_to_top, RDY);
    end
    cycle(1'b0, RST, 24'h0);
    n_chk++;
    if (link.command_to_top !== RDONE || dut.center !== 24'h0 ||
        dut.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full: got %h ctr=%h v=%b want %h ctr=0 v=0",
               link.command_to_top, dut.center, dut.valid, RDONE);
    end
  endtask

  task automatic test_reset_priority;
    cycle(1'b1, SWAP, 24'hABCDEF);
    n_chk++;
    if (link.command_to_top !== NOP || link.data_to_top !== 24'h0 ||
        dut.center !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_prio: got %h/%h ctr=%h want %h/0 ctr=0",
               link.command_to_top, link.data_to_top, dut.center, NOP);
    end
    cycle(1'b0, NOP, 24'h0);
    n_chk++;
    if (link.command_to_top !== NOP || dut.center !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_prio_next: got %h ctr=%h want %h ctr=0",
               link.command_to_top, dut.center, NOP);
    end
  endtask

  task automatic test_unknown;
    cycle(1'b0, RST, 24'h0);
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, FILL, 24'h123456);
    cycle(1'b0, BUSY, 24'h999999);
    n_chk++;
    if (link.command_to_top !== NOP || link.data_to_top !== 24'h0 ||
        dut.center !== 24'h123456) begin
      n_fail++;
      $display("FAIL busy_code: got %h/%h ctr=%h want %h/0 ctr=123456",
               link.command_to_top, link.data_to_top, dut.center, NOP);
    end
    cycle(1'b0, FDONE, 24'h888888);
    n_chk++;
    if (link.command_to_top !== NOP || dut.center !== 24'h123456 ||
        proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fdone_code: got %h ctr=%h perr=%b want %h ctr=123456 0",
               link.command_to_top, dut.center, proto_err, NOP);
    end
  endtask

  task automatic test_protocol;
    cycle(1'b1, NOP, 24'h0);
    cycle(1'b0, SWAP, 24'h010203);
    n_chk++;
    if (proto_err !== PCHK || link.command_to_top !== RECV) begin
      n_fail++;
      $display("FAIL perr_uninit: perr=%b cmd=%h want %b/%h",
               proto_err, link.command_to_top, PCHK, RECV);
    end
    cycle(1'b0, NOP, 24'h0);
    cycle(1'b0, RST, 24'h0);
    n_chk++;
    if (proto_err !== PCHK) begin
      n_fail++;
      $display("FAIL perr_sticky: perr=%b want %b", proto_err, PCHK);
    end
    cycle(1'b1, NOP, 24'h0);
    cycle(1'b0, RST, 24'h0);
    cycle(1'b0, NOP, 24'h0);
    n_chk++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_clear: perr=%b want 0", proto_err);
    end
    cycle(1'b0, 5'h0b, 24'h0);
    n_chk++;
    if (proto_err !== PCHK || link.command_to_top !== NOP) begin
      n_fail++;
      $display("FAIL perr_undef: perr=%b cmd=%h want %b/%h",
               proto_err, link.command_to_top, PCHK, NOP);
    end
  endtask

  initial begin
    link.command_from_top = NOP;
    link.data_from_top = 24'h0;
    test_reset;
    test_fill;
    test_swap_empty;
    test_axis_swap;
    test_back_to_back;
    test_reset_priority;
    test_unknown;
    test_protocol;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
